// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: load extraction, fault detection, register file write port
module writeback_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic            wb_is_load,
  input  logic [2:0]      wb_funct3,
  input  logic [1:0]      wb_addr_lo,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic [4:0]      rf_dest,
  output logic            rf_write_en,
  output logic [XLEN-1:0] rf_data,
  output logic            retire,
  output logic            load_fault
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  // Counter only needs to hold 0 .. MEM_TIMEOUT-1; expiry is detected on the last value.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [4:0]    rd_q;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;

  logic            go_commit;
  logic            c_fault;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] c_data;

  // Illegal load width, or a halfword/word access that is not naturally aligned.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = lo[0];
      3'b010:         load_bad = (lo != 2'b00);
      default:        load_bad = 1'b1;
    endcase
  endfunction

  // Select the addressed byte/half from the aligned word and extend it to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lo +: 8];
    h = word[16*lo[1] +: 16];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  assign wb_ready = (state == IDLE);

  // Decide whether this cycle completes an instruction, and with what result.
  always_comb begin
    go_commit = 1'b0;
    c_fault   = 1'b0;
    c_rd      = rd_q;
    c_data    = '0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          c_rd = wb_rd;
          if (!wb_is_load) begin
            go_commit = 1'b1;
            c_data    = wb_alu_result;
          end else if (load_bad(wb_funct3, wb_addr_lo)) begin
            go_commit = 1'b1;
            c_fault   = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          go_commit = 1'b1;
          c_fault   = mem_err;
          c_data    = mem_err ? '0 : extract(funct3_q, addr_lo_q, mem_rdata);
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
          go_commit = 1'b1;
          c_fault   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM with registered register-file port and retire/fault pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      rf_dest     <= '0;
      rf_write_en <= 1'b0;
      rf_data     <= '0;
      retire      <= 1'b0;
      load_fault  <= 1'b0;
    end else if (go_commit) begin
      state       <= COMMIT;
      rf_dest     <= c_rd;
      rf_data     <= c_fault ? '0 : c_data;
      rf_write_en <= !c_fault && (c_rd != 5'd0);
      retire      <= 1'b1;
      load_fault  <= c_fault;
      if (state == IDLE) begin
        rd_q      <= wb_rd;
        funct3_q  <= wb_funct3;
        addr_lo_q <= wb_addr_lo;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wb_valid) begin
            rd_q      <= wb_rd;
            funct3_q  <= wb_funct3;
            addr_lo_q <= wb_addr_lo;
            wait_cnt  <= '0;
            state     <= WAIT_MEM;
          end
        end
        WAIT_MEM: wait_cnt <= wait_cnt + 1'b1;
        default: begin
          state       <= IDLE;
          rf_dest     <= '0;
          rf_write_en <= 1'b0;
          rf_data     <= '0;
          retire      <= 1'b0;
          load_fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_is_load;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;
  logic [31:0] wb_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [4:0]  rf_dest;
  logic        rf_write_en;
  logic [31:0] rf_data;
  logic        retire;
  logic        load_fault;

  int n_vec = 0;
  int n_err = 0;

  writeback_unit #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_is_load(wb_is_load),
    .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .wb_alu_result(wb_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rf_dest(rf_dest), .rf_write_en(rf_write_en), .rf_data(rf_data),
    .retire(retire), .load_fault(load_fault)
  );

  always #5 clk = ~clk;

  // {retire, load_fault, rf_write_en, rf_dest, rf_data}
  wire [39:0] commit_obs = {retire, load_fault, rf_write_en, rf_dest, rf_data};

  // Stimulus only: advance to the next falling edge, offer one instruction, drop it after the edge.
  task automatic issue(input logic ld, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] alu);
    @(negedge clk);
    wb_valid = 1'b1; wb_is_load = ld; wb_rd = rd; wb_funct3 = f3;
    wb_addr_lo = lo; wb_alu_result = alu;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  // Stimulus only: one-cycle memory response from the current falling edge.
  task automatic respond(input logic [31:0] data, input logic err);
    mem_rvalid = 1'b1; mem_rdata = data; mem_err = err;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_is_load = 1'b0; wb_funct3 = '0;
    wb_addr_lo = '0; wb_alu_result = '0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_ready, commit_obs} !== {1'b1, 40'h0}) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", {wb_ready, commit_obs}, {1'b1, 40'h0});
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_ready, commit_obs} !== {1'b1, 40'h0}) begin
      n_err++; $display("FAIL reset_release: got %h want %h", {wb_ready, commit_obs}, {1'b1, 40'h0});
    end
  endtask

  task automatic test_alu;
    issue(1'b0, 5'd5, 3'b000, 2'b00, 32'h0000_1234);
    @(negedge clk);
    n_vec++;
    if ({wb_ready, commit_obs} !== {1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234}) begin
      n_err++; $display("FAIL alu_rd5: got %h want %h", {wb_ready, commit_obs},
                        {1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234});
    end
    issue(1'b0, 5'd0, 3'b000, 2'b00, 32'hDEAD_BEEF);
    @(negedge clk);
    n_vec++;
    if (commit_obs !== {1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL alu_rd0: got %h want %h", commit_obs,
                        {1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000, 3'b101, 3'b001};
    logic [1:0]  lo [8] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [31:0] rd [8] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'hBEEF_1234, 32'hBEEF_1234,
                            32'h1234_5678, 32'h80AA_BBCC, 32'hBEEF_1234, 32'h0000_8001};
    logic [31:0] ex [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF,
                            32'h1234_5678, 32'hFFFF_FFBB, 32'h0000_1234, 32'hFFFF_8001};
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 5'(10 + i), f3[i], lo[i], 32'h5555_5555);
      @(negedge clk);
      n_vec++;
      if ({wb_ready, retire} !== 2'b00) begin
        n_err++; $display("FAIL load%0d_wait: got %b want 00", i, {wb_ready, retire});
      end
      respond(rd[i], 1'b0);
      @(negedge clk);
      n_vec++;
      if (commit_obs !== {1'b1, 1'b0, 1'b1, 5'(10 + i), ex[i]}) begin
        n_err++; $display("FAIL load%0d_data: got %h want %h", i, commit_obs,
                          {1'b1, 1'b0, 1'b1, 5'(10 + i), ex[i]});
      end
    end
  endtask

  task automatic test_faults;
    logic [2:0] f3 [3] = '{3'b010, 3'b101, 3'b011};
    logic [1:0] lo [3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'd6, f3[i], lo[i], 32'hFFFF_FFFF);
      @(negedge clk);
      n_vec++;
      if (commit_obs !== {1'b1, 1'b1, 1'b0, 5'd6, 32'h0}) begin
        n_err++; $display("FAIL early_fault%0d: got %h want %h", i, commit_obs,
                          {1'b1, 1'b1, 1'b0, 5'd6, 32'h0});
      end
    end
    issue(1'b1, 5'd7, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    respond(32'h1234_5678, 1'b1);
    @(negedge clk);
    n_vec++;
    if (commit_obs !== {1'b1, 1'b1, 1'b0, 5'd7, 32'h0}) begin
      n_err++; $display("FAIL mem_err: got %h want %h", commit_obs, {1'b1, 1'b1, 1'b0, 5'd7, 32'h0});
    end
  endtask

  task automatic test_timeout;
    issue(1'b1, 5'd9, 3'b000, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({wb_ready, retire} !== 2'b00) begin
        n_err++; $display("FAIL timeout_wait%0d: got %b want 00", i, {wb_ready, retire});
      end
    end
    @(negedge clk);
    n_vec++;
    if (commit_obs !== {1'b1, 1'b1, 1'b0, 5'd9, 32'h0}) begin
      n_err++; $display("FAIL timeout_fault: got %h want %h", commit_obs, {1'b1, 1'b1, 1'b0, 5'd9, 32'h0});
    end
    issue(1'b1, 5'd3, 3'b100, 2'd0, 32'h0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    respond(32'h0000_00F0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (commit_obs !== {1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_00F0}) begin
      n_err++; $display("FAIL rvalid_at_expiry: got %h want %h", commit_obs,
                        {1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_00F0});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wb_valid = 1'b1; wb_is_load = 1'b0; wb_rd = 5'd7; wb_alu_result = 32'hAAAA_0001;
    @(posedge clk); #1;
    wb_rd = 5'd8; wb_alu_result = 32'hBBBB_0002;
    @(negedge clk);
    n_vec++;
    if ({wb_ready, commit_obs} !== {1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hAAAA_0001}) begin
      n_err++; $display("FAIL b2b_first: got %h want %h", {wb_ready, commit_obs},
                        {1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hAAAA_0001});
    end
    @(negedge clk);
    n_vec++;
    if ({wb_ready, retire} !== 2'b10) begin
      n_err++; $display("FAIL b2b_gap: got %b want 10", {wb_ready, retire});
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (commit_obs !== {1'b1, 1'b0, 1'b1, 5'd8, 32'hBBBB_0002}) begin
      n_err++; $display("FAIL b2b_second: got %h want %h", commit_obs,
                        {1'b1, 1'b0, 1'b1, 5'd8, 32'hBBBB_0002});
    end
  endtask

  task automatic test_reset_mid_wait;
    issue(1'b1, 5'd4, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({wb_ready, retire, rf_write_en} !== 3'b100) begin
      n_err++; $display("FAIL reset_in_wait: got %b want 100", {wb_ready, retire, rf_write_en});
    end
    @(negedge clk);
    reset = 1'b0;
    respond(32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({wb_ready, retire, rf_write_en} !== 3'b100) begin
        n_err++; $display("FAIL after_reset%0d: got %b want 100", i, {wb_ready, retire, rf_write_en});
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_faults;
    test_timeout;
    test_back_to_back;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
